has_tripped: RTL and testbench



---
 rtl/has_tripped_if.sv | 43 ++++
 rtl/has_tripped.sv | 181 ++++++++++++++++++
 tb/tb_has_tripped.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/has_tripped_if.sv
// ---------------------------------------------------------------------------
// has_tripped_if
//   Groups the ADC pin signals, the start pulse and the trip/sample results
//   of the has_tripped trip detector into one bundle.
//
//   Signals:
//     DATA_IN        ADC serial data (ADC -> detector)
//     startSequence  single-cycle start pulse (control -> detector)
//     ADC_CLK        serial clock to the ADC, idles low
//     ADC_CS         active-low ADC chip select, idles high
//     hasTripped     sticky trip flag
//     theByte        most recent captured 10-bit sample
//
//   Modports:
//     master  the detector itself (drives the ADC pins and the results)
//     slave   the surroundings (ADC model / control logic)
// ---------------------------------------------------------------------------
interface has_tripped_if;
  logic       DATA_IN;
  logic       startSequence;
  logic       ADC_CLK;
  logic       ADC_CS;
  logic       hasTripped;
  logic [9:0] theByte;

  modport master (
    input  DATA_IN,
    input  startSequence,
    output ADC_CLK,
    output ADC_CS,
    output hasTripped,
    output theByte
  );

  modport slave (
    output DATA_IN,
    output startSequence,
    input  ADC_CLK,
    input  ADC_CS,
    input  hasTripped,
    input  theByte
  );
endinterface

// File: rtl/has_tripped.sv
// ---------------------------------------------------------------------------
// has_tripped
//   Trip detector. After a start pulse it runs back-to-back conversions on a
//   10-bit serial ADC (chip select + clock, MSB first, 3 leading null bits).
//   Each captured sample is reported on theByte; the first sample at or above
//   THRESHOLD latches hasTripped and parks the machine until reset.
//
//   Parameters:
//     HALF_PER   ADC_CLK half-period in CLK cycles (>= 1)
//     CS_GAP     CLK cycles ADC_CS stays high between conversions (>= 1)
//     THRESHOLD  trip level, 10-bit unsigned
//
//   Ports:
//     CLK   system clock, rising edge
//     RST   synchronous active-high reset
//     bus   has_tripped_if.master: DATA_IN, startSequence in;
//           ADC_CLK, ADC_CS, hasTripped, theByte out (all registered)
// ---------------------------------------------------------------------------
module has_tripped #(
  parameter int HALF_PER  = 2,
  parameter int CS_GAP    = 4,
  parameter int THRESHOLD = 450
) (
  input logic           CLK,
  input logic           RST,
  has_tripped_if.master bus
);

  // One divider serves both the half-period holds and the CS gap.
  localparam int              CNT_MAX    = (HALF_PER > CS_GAP) ? HALF_PER : CS_GAP;
  localparam int              CW         = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   HALF_LAST  = CW'(HALF_PER - 1);
  localparam logic [CW-1:0]   GAP_LAST   = CW'(CS_GAP - 1);
  localparam logic [9:0]      TRIP_LEVEL = 10'(THRESHOLD);
  localparam logic [3:0]      NUM_BITS   = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    CLK_LO,
    GAP,
    TRIPPED
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] div_cnt, next_div;
  logic [3:0]    bit_cnt, next_bit;
  logic [9:0]    shift_reg, next_shift;
  logic          cs, next_cs;
  logic          aclk, next_aclk;
  logic          tripped, next_tripped;
  logic [9:0]    sample, next_sample;

  logic half_done;
  logic gap_done;

  assign half_done = (div_cnt == HALF_LAST);
  assign gap_done  = (div_cnt == GAP_LAST);

  // The 10-bit shift register naturally drops the two null samples: after
  // 12 shifts only samples 3..12 (data bits 9..0) remain.
  always_comb begin
    next_state   = state;
    next_div     = div_cnt;
    next_bit     = bit_cnt;
    next_shift   = shift_reg;
    next_cs      = cs;
    next_aclk    = aclk;
    next_tripped = tripped;
    next_sample  = sample;

    case (state)
      IDLE: begin
        next_cs   = 1'b1;
        next_aclk = 1'b0;
        next_div  = '0;
        if (bus.startSequence) begin
          next_cs    = 1'b0;
          next_bit   = '0;
          next_state = SETUP;
        end
      end

      SETUP: begin
        if (half_done) begin
          next_div   = '0;
          next_aclk  = 1'b1;
          next_state = CLK_HI;
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end

      // Sampling on the falling ADC_CLK edge gives the ADC the whole high
      // phase to settle the bit it shifted out on the rising edge.
      CLK_HI: begin
        if (half_done) begin
          next_div   = '0;
          next_aclk  = 1'b0;
          next_shift = {shift_reg[8:0], bus.DATA_IN};
          next_bit   = bit_cnt + 4'd1;
          next_state = CLK_LO;
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end

      CLK_LO: begin
        if (half_done) begin
          next_div = '0;
          if (bit_cnt < NUM_BITS) begin
            next_aclk  = 1'b1;
            next_state = CLK_HI;
          end else begin
            next_cs     = 1'b1;
            next_sample = shift_reg;
            if (shift_reg >= TRIP_LEVEL) begin
              next_tripped = 1'b1;
              next_state   = TRIPPED;
            end else begin
              next_state = GAP;
            end
          end
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end

      GAP: begin
        if (gap_done) begin
          next_div   = '0;
          next_cs    = 1'b0;
          next_bit   = '0;
          next_state = SETUP;
        end else begin
          next_div = div_cnt + 1'b1;
        end
      end

      TRIPPED: begin
        next_cs      = 1'b1;
        next_aclk    = 1'b0;
        next_tripped = 1'b1;
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Reset discards any partial conversion along with the last sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      cs        <= 1'b1;
      aclk      <= 1'b0;
      tripped   <= 1'b0;
      sample    <= '0;
    end else begin
      state     <= next_state;
      div_cnt   <= next_div;
      bit_cnt   <= next_bit;
      shift_reg <= next_shift;
      cs        <= next_cs;
      aclk      <= next_aclk;
      tripped   <= next_tripped;
      sample    <= next_sample;
    end
  end

  assign bus.ADC_CS     = cs;
  assign bus.ADC_CLK    = aclk;
  assign bus.hasTripped = tripped;
  assign bus.theByte    = sample;

endmodule

// File: tb/tb_has_tripped.sv
// ---------------------------------------------------------------------------
// tb_has_tripped
//   Directed bench for has_tripped with default parameters (HALF_PER=2,
//   CS_GAP=4, THRESHOLD=450). A small ADC model shifts out {3'b000, value}
//   MSB first, advancing on each ADC_CLK rise and reloading while ADC_CS=1.
// ---------------------------------------------------------------------------
module tb_has_tripped;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  has_tripped_if ifc ();

  has_tripped #(
    .HALF_PER (2),
    .CS_GAP   (4),
    .THRESHOLD(450)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;

  // ADC model: first null bit is present while CS is high, each ADC_CLK
  // rise moves to the next bit of the 13-bit word.
  logic [9:0]  adc_value = 10'd0;
  logic [12:0] adc_word;
  int          bit_idx = 0;

  assign adc_word    = {3'b000, adc_value};
  assign ifc.DATA_IN = adc_word[12 - bit_idx];

  always @(posedge ifc.ADC_CLK or posedge ifc.ADC_CS) begin
    if (ifc.ADC_CS) bit_idx <= 0;
    else if (bit_idx < 12) bit_idx <= bit_idx + 1;
  end

  // Monitor: CS-low length and ADC_CLK pulse count of the current conversion.
  int   low_len = 0;
  int   pulses = 0;
  logic prev_cs = 1'b1;
  logic prev_aclk = 1'b0;

  always @(negedge clk) begin
    if (ifc.ADC_CS === 1'b0) begin
      if (prev_cs === 1'b1) begin
        low_len = 1;
        pulses  = 0;
      end else begin
        low_len++;
      end
      if (ifc.ADC_CLK === 1'b1 && prev_aclk === 1'b0) pulses++;
    end
    prev_cs   = ifc.ADC_CS;
    prev_aclk = ifc.ADC_CLK;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ifc.startSequence = 1'b1;
    step(1);
    ifc.startSequence = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Returns just after the next ADC_CS rise that ends a conversion.
  task automatic wait_eoc(input int budget, output bit seen);
    bit was_low;
    was_low = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (ifc.ADC_CS === 1'b0) was_low = 1'b1;
      else if (was_low) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    int activity;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++; if (ifc.ADC_CS !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs: got %b expected 1", ifc.ADC_CS); end
    checks++; if (ifc.ADC_CLK !== 1'b0) begin errors++; $display("[TB] FAIL reset_aclk: got %b expected 0", ifc.ADC_CLK); end
    checks++; if (ifc.hasTripped !== 1'b0) begin errors++; $display("[TB] FAIL reset_trip: got %b expected 0", ifc.hasTripped); end
    checks++; if (ifc.theByte !== 10'd0) begin errors++; $display("[TB] FAIL reset_byte: got %0d expected 0", ifc.theByte); end
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ifc.ADC_CS !== 1'b1 || ifc.ADC_CLK !== 1'b0) activity++;
    end
    checks++; if (activity != 0) begin errors++; $display("[TB] FAIL idle_quiet: got %0d active cycles expected 0", activity); end
  endtask

  task automatic test_single_capture();
    bit seen;
    int gap;
    adc_value = 10'd200;
    pulse_start();
    checks++; if (ifc.ADC_CS !== 1'b0) begin errors++; $display("[TB] FAIL start_cs: got %b expected 0", ifc.ADC_CS); end
    step(1);
    checks++; if (ifc.ADC_CLK !== 1'b0) begin errors++; $display("[TB] FAIL setup_aclk: got %b expected 0", ifc.ADC_CLK); end
    step(1);
    checks++; if (ifc.ADC_CLK !== 1'b1) begin errors++; $display("[TB] FAIL first_rise: got %b expected 1", ifc.ADC_CLK); end
    wait_eoc(200, seen);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL single_eoc: got timeout expected ADC_CS rise"); end
    checks++; if (ifc.theByte !== 10'd200) begin errors++; $display("[TB] FAIL single_byte: got %0d expected 200", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b0) begin errors++; $display("[TB] FAIL single_trip: got %b expected 0", ifc.hasTripped); end
    checks++; if (pulses != 12) begin errors++; $display("[TB] FAIL single_pulses: got %0d expected 12", pulses); end
    checks++; if (low_len != 50) begin errors++; $display("[TB] FAIL single_cs_low: got %0d expected 50", low_len); end
    gap = 1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (ifc.ADC_CS === 1'b1) gap++;
      else break;
    end
    checks++; if (gap != 4) begin errors++; $display("[TB] FAIL single_gap: got %0d expected 4", gap); end
  endtask

  task automatic test_mid_reset();
    bit seen;
    bit hit;
    int bad;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step(1);
      if (ifc.ADC_CS === 1'b0 && pulses == 6) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL mid_reach6: got timeout expected 6 pulses"); end
    do_reset();
    checks++; if (ifc.ADC_CS !== 1'b1) begin errors++; $display("[TB] FAIL mid_cs: got %b expected 1", ifc.ADC_CS); end
    checks++; if (ifc.ADC_CLK !== 1'b0) begin errors++; $display("[TB] FAIL mid_aclk: got %b expected 0", ifc.ADC_CLK); end
    checks++; if (ifc.theByte !== 10'd0) begin errors++; $display("[TB] FAIL mid_byte: got %0d expected 0", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b0) begin errors++; $display("[TB] FAIL mid_trip: got %b expected 0", ifc.hasTripped); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (ifc.ADC_CS !== 1'b1 || ifc.ADC_CLK !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mid_idle: got %0d active cycles expected 0", bad); end
    adc_value = 10'd77;
    pulse_start();
    wait_eoc(200, seen);
    checks++; if (ifc.theByte !== 10'd77 || !seen) begin errors++; $display("[TB] FAIL restart_byte: got %0d expected 77", ifc.theByte); end
    checks++; if (pulses != 12) begin errors++; $display("[TB] FAIL restart_pulses: got %0d expected 12", pulses); end
  endtask

  task automatic test_extremes();
    bit seen;
    int bad;
    adc_value = 10'd0;
    wait_eoc(200, seen);
    checks++; if (ifc.theByte !== 10'd0 || !seen) begin errors++; $display("[TB] FAIL zero_byte: got %0d expected 0", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b0) begin errors++; $display("[TB] FAIL zero_trip: got %b expected 0", ifc.hasTripped); end
    adc_value = 10'd1023;
    wait_eoc(200, seen);
    checks++; if (ifc.theByte !== 10'd1023 || !seen) begin errors++; $display("[TB] FAIL max_byte: got %0d expected 1023", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b1) begin errors++; $display("[TB] FAIL max_trip: got %b expected 1", ifc.hasTripped); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) pulse_start();
      else step(1);
      if (ifc.ADC_CS !== 1'b1 || ifc.ADC_CLK !== 1'b0 || ifc.hasTripped !== 1'b1 || ifc.theByte !== 10'd1023) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL max_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_ramp();
    bit          seen;
    bit          low_seen;
    int          bad;
    logic [9:0]  vals [4];
    vals[0] = 10'd200; vals[1] = 10'd300; vals[2] = 10'd400; vals[3] = 10'd500;
    do_reset();
    adc_value = vals[0];
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_eoc(200, seen);
      checks++; if (ifc.theByte !== vals[i] || !seen) begin errors++; $display("[TB] FAIL ramp_byte%0d: got %0d expected %0d", i, ifc.theByte, vals[i]); end
      checks++; if (ifc.hasTripped !== (i == 3)) begin errors++; $display("[TB] FAIL ramp_trip%0d: got %b expected %b", i, ifc.hasTripped, (i == 3)); end
      if (i == 1) begin
        checks++; if (low_len != 50 || pulses != 12) begin errors++; $display("[TB] FAIL ignored_start: got low %0d pulses %0d expected low 50 pulses 12", low_len, pulses); end
      end
      if (i < 3) adc_value = vals[i + 1];
      if (i == 0) begin
        low_seen = 1'b0;
        for (int k = 0; k < 50 && !low_seen; k++) begin
          step(1);
          if (ifc.ADC_CS === 1'b0) low_seen = 1'b1;
        end
        step(10);
        pulse_start();
      end
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) pulse_start();
      else step(1);
      if (ifc.ADC_CS !== 1'b1 || ifc.ADC_CLK !== 1'b0 || ifc.hasTripped !== 1'b1 || ifc.theByte !== 10'd500) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ramp_hold: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_threshold();
    bit seen;
    do_reset();
    adc_value = 10'd449;
    pulse_start();
    wait_eoc(200, seen);
    checks++; if (ifc.theByte !== 10'd449 || !seen) begin errors++; $display("[TB] FAIL thr449_byte: got %0d expected 449", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b0) begin errors++; $display("[TB] FAIL thr449_trip: got %b expected 0", ifc.hasTripped); end
    adc_value = 10'd450;
    wait_eoc(200, seen);
    checks++; if (ifc.theByte !== 10'd450 || !seen) begin errors++; $display("[TB] FAIL thr450_byte: got %0d expected 450", ifc.theByte); end
    checks++; if (ifc.hasTripped !== 1'b1) begin errors++; $display("[TB] FAIL thr450_trip: got %b expected 1", ifc.hasTripped); end
    step(8);
    checks++; if (ifc.ADC_CS !== 1'b1 || ifc.hasTripped !== 1'b1) begin errors++; $display("[TB] FAIL thr450_hold: got cs %b trip %b expected cs 1 trip 1", ifc.ADC_CS, ifc.hasTripped); end
  endtask

  initial begin
    ifc.startSequence = 1'b0;
    test_reset();
    test_single_capture();
    test_mid_reset();
    test_extremes();
    test_ramp();
    test_threshold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
